// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full adder and one carry flop, LSB first.
// The visible result is only updated on the final bit, so it holds through a following run.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] result;
    logic [CW-1:0]    count;
    logic             carry;
    logic             bit_sum;
    logic             bit_carry;
    logic             accept;
    logic             last;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last      = (state == RUN) && (count == LAST);
    assign bit_sum   = a_q[count] ^ b_q[count] ^ carry;
    assign bit_carry = (a_q[count] & b_q[count]) | (carry & (a_q[count] ^ b_q[count]));
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Partial result with the current bit merged in; becomes the output on the last bit.
    always_comb begin
        result        = acc;
        result[count] = bit_sum;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            count <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            count <= '0;
        end else if (state == RUN) begin
            acc   <= result;
            carry <= bit_carry;
            count <= count + CW'(1);
            if (last) begin
                sum  <= result;
                cout <= bit_carry;
                ovf  <= carry ^ bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder: WIDTH=8 scenarios plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         start2;
    logic         sub2;
    logic         cin2;
    logic [1:0]   a2;
    logic [1:0]   b2;
    logic         busy2;
    logic         done2;
    logic [1:0]   sum2;
    logic         cout2;
    logic         ovf2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .sub   (sub2),
        .a     (a2),
        .b     (b2),
        .cin   (cin2),
        .busy  (busy2),
        .done  (done2),
        .sum   (sum2),
        .cout  (cout2),
        .ovf   (ovf2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one start pulse, then scrambles the operands so the run must use its latched copy.
    task automatic apply_stimulus(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tcin, input logic tsub);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tcin;
        sub   = tsub;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        sub   = 1'($urandom);
    endtask

    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < 4 * W) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_output(input string tag, input logic [W-1:0] esum,
                                input logic ecout, input logic eovf);
        int lat;
        int bcnt;
        wait_done(lat, bcnt);
        check({tag, "_latency"}, lat, W);
        check({tag, "_busy_cycles"}, bcnt, W);
        check({tag, "_done"}, done, 1);
        check({tag, "_sum"}, sum, esum);
        check({tag, "_cout"}, cout, ecout);
        check({tag, "_ovf"}, ovf, eovf);
        @(negedge clk);
        check({tag, "_done_pulse"}, {busy, done}, 2'b00);
        check({tag, "_sum_hold"}, sum, esum);
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;
        int held;
        logic [W-1:0] got_sum;
        logic [1:0]   bb;
        logic [2:0]   tot;
        logic [3:0]   exp2;

        rst_n  = 1'b0;
        start  = 1'b1;
        a      = 8'h01;
        b      = 8'h01;
        cin    = 1'b0;
        sub    = 1'b0;
        start2 = 1'b0;
        a2     = 2'b00;
        b2     = 2'b00;
        cin2   = 1'b0;
        sub2   = 1'b0;

        // Start is held high through reset and must not be taken.
        repeat (2) @(negedge clk);
        check("reset_busy_done", {busy, done}, 2'b00);
        check("reset_results", {sum, cout, ovf}, 10'h0);
        check("reset_w2", {busy2, done2, sum2, cout2, ovf2}, 6'h0);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_after_reset", {busy, done}, 2'b00);

        apply_stimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        check_output("add_wrap", 8'h00, 1'b1, 1'b0);
        apply_stimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        check_output("add_ovf", 8'h80, 1'b0, 1'b1);
        apply_stimulus(8'h7F, 8'h00, 1'b1, 1'b0);
        check_output("add_cin_ovf", 8'h80, 1'b0, 1'b1);
        apply_stimulus(8'hA5, 8'h5A, 1'b1, 1'b0);
        check_output("add_cin_carry", 8'h00, 1'b1, 1'b0);
        apply_stimulus(8'h05, 8'h07, 1'b0, 1'b1);
        check_output("sub_borrow", 8'hFE, 1'b0, 1'b0);
        apply_stimulus(8'h10, 8'h10, 1'b1, 1'b1);
        check_output("sub_cin_ignored", 8'h00, 1'b1, 1'b0);

        // Second start and operand churn during RUN must not disturb the first operation.
        apply_stimulus(8'h10, 8'h20, 1'b0, 1'b0);
        dcnt    = 0;
        got_sum = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                dcnt++;
                got_sum = sum;
            end
            start = (i == 2);
            a     = W'($urandom);
            b     = W'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        check("interf_done_count", dcnt, 1);
        check("interf_sum", got_sum, 8'h30);
        check("interf_idle", busy, 1'b0);

        apply_stimulus(8'h80, 8'h01, 1'b0, 1'b1);
        check_output("sub_ovf", 8'h7F, 1'b1, 1'b1);

        // Reset lands on the edge that would process bit 4.
        apply_stimulus(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_busy_done", {busy, done}, 2'b00);
        check("midrst_results", {sum, cout, ovf}, 10'h0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dcnt++;
            @(negedge clk);
        end
        check("midrst_no_done", dcnt, 0);
        apply_stimulus(8'h12, 8'h34, 1'b0, 1'b0);
        check_output("after_rst", 8'h46, 1'b0, 1'b0);

        // Back-to-back: new start issued in the DONE cycle.
        apply_stimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bcnt);
        check("b2b_first_latency", lat, W);
        check("b2b_first_sum", sum, 8'h80);
        a     = 8'h01;
        b     = 8'h02;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy_rise", {busy, done}, 2'b10);
        held = 1;
        lat  = 0;
        while (!done && lat < 4 * W) begin
            if (sum !== 8'h80) held = 0;
            @(negedge clk);
            lat++;
        end
        check("b2b_hold", held, 1);
        check("b2b_second_latency", lat, W);
        check("b2b_second_result", {sum, cout, ovf}, {8'h03, 1'b0, 1'b0});

        // Exhaustive sweep of the 2-bit instance against an arithmetic model.
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 4; x++) begin
                    for (int y = 0; y < 4; y++) begin
                        @(negedge clk);
                        a2     = 2'(x);
                        b2     = 2'(y);
                        cin2   = 1'(c);
                        sub2   = 1'(s);
                        start2 = 1'b1;
                        @(negedge clk);
                        start2 = 1'b0;
                        lat    = 0;
                        while (!done2 && lat < 10) begin
                            @(negedge clk);
                            lat++;
                        end
                        bb   = (s != 0) ? ~2'(y) : 2'(y);
                        tot  = 3'(x) + 3'(bb) + ((s != 0) ? 3'd1 : 3'(c));
                        exp2 = {tot[2], (2'(x) >> 1) == (bb >> 1) && tot[1] != 1'(x >> 1), tot[1:0]};
                        check($sformatf("w2_s%0d_c%0d_a%0d_b%0d", s, c, x, y),
                              {lat[3:0], cout2, ovf2, sum2}, {4'd2, exp2});
                    end
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
